alu_cu: RTL and testbench
=========================

ALU_CU -- requirements
Module: alu_cu

Interface
- REQ-001 SHALL have parameter RTYPE_OP, default 5'h1F, meaning the ALUOP value that selects funct-field decode.
- REQ-002 SHALL have parameter NOP_CODE, default 5'h1E, meaning the control code emitted for an unrecognised funct.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-005 SHALL have port ALUOP, input, 5 bits: ALU operation class from the main decoder.
- REQ-006 SHALL have port funccode, input, 6 bits: MIPS R-type funct field.
- REQ-007 SHALL have port ALUOPCtrl, output, 5 bits: final ALU operation code.
- REQ-008 SHALL order ports clk, rst_n, ALUOP, funccode, ALUOPCtrl, followed by any optional ports.

Function
- REQ-009 SHALL drive ALUOPCtrl as a purely combinational function of ALUOP and funccode, with zero-cycle latency and no dependence on clk.
- REQ-010 SHALL pass ALUOP through unchanged to ALUOPCtrl whenever ALUOP != RTYPE_OP, regardless of funccode.
- REQ-011 SHALL, when ALUOP == RTYPE_OP, map funccode to ALUOPCtrl as follows:
  - 20 ADD=00, 21 ADDU=01, 22 SUB=02, 23 SUBU=03
  - 24 AND=04, 25 OR=05, 26 XOR=06, 27 NOR=07
  - 2A SLT=08, 2B SLTU=09
  - 00 SLL=0A, 02 SRL=0B, 03 SRA=0C, 04 SLLV=0D, 06 SRLV=0E, 07 SRAV=0F
  - 18 MULT=11, 19 MULTU=12, 1A DIV=13, 1B DIVU=14
  - 10 MFHI=15, 12 MFLO=16, 11 MTHI=17, 13 MTLO=18
  - 08 JR=19, 09 JALR=1A
  - All values are hex.
- REQ-012 SHALL reserve code 10 (LUI) for pass-through use only; funct decode never produces it.
- REQ-013 SHALL output NOP_CODE for any funct value not listed in REQ-011 when ALUOP == RTYPE_OP.
- REQ-014 SHALL never output X or Z for any 2-state input combination; the decode SHALL be full, with a default branch.

Reset
- REQ-015 SHALL leave ALUOPCtrl unaffected by rst_n, since it is combinational.
- REQ-016 SHALL asynchronously clear every register in the block to 0 when rst_n is low, and release the registers on the first clk rising edge after rst_n goes high.

Configuration
- REQ-017 SHALL, when macro ALU_CU_ILLEGAL_FLAG_EN is defined, add output illegal_flag (1 bit, last in the port list).
- REQ-018 SHALL set illegal_flag on the clk rising edge at which ALUOP == RTYPE_OP and funccode is unlisted, keep it set (sticky), and clear it only by reset (reset value 0).
- REQ-019 SHALL, when ALU_CU_ILLEGAL_FLAG_EN is undefined, omit illegal_flag, contain no flops, and leave clk and rst_n connected but functionally unused.

Structure
- REQ-020 SHALL take the ALU operation code constants (00..1A, NOP_CODE) and the funct constants from a shared package alu_pkg, which is also used by the ALU.
- REQ-021 SHALL place the funct decode table in one sub-module, alu_funct_dec (funccode in, code and illegal bit out), instantiated once.

Verification
- REQ-022 SHALL cover R-type ADD: ALUOP=1F, funccode=20 -> ALUOPCtrl=00 in the same cycle.
- REQ-023 SHALL cover the full funct sweep: ALUOP=1F with funccode=00..3F -> REQ-011 codes, all others 1E (e.g. 2A->08, 18->11, 05->1E).
- REQ-024 SHALL cover pass-through: ALUOP=02, funccode=24 -> 02; ALUOP=10, funccode=00 -> 10.
- REQ-025 SHALL cover input changes applied at a clk rising edge, checked at the next rising edge: the output matches the new inputs with no one-cycle lag, over at least 50 vectors.
- REQ-026 SHALL cover the ALU_CU_ILLEGAL_FLAG_EN build:
  - hold rst_n=0 -> illegal_flag=0;
  - apply ALUOP=1F, funccode=3F for one edge -> illegal_flag=1, remaining 1 after legal inputs;
  - assert rst_n low mid-cycle -> illegal_flag=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg -- constants shared by the ALU control unit and the ALU datapath.
//
// Contents:
//   alu_op_t  : 5-bit ALU operation code carried from control to the ALU
//   funct_t   : 6-bit MIPS R-type funct field
//   ALU_*     : ALU operation codes (0x00..0x1A, NOP, R-type selector)
//   FN_*      : MIPS funct field values understood by the funct decoder
//   is_listed_funct() : reports whether a funct value has an ALU code
//
// The ALU itself switches on the same ALU_* values, so any renumbering here
// must be made once and picked up by both sides.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef logic [4:0] alu_op_t;
    typedef logic [5:0] funct_t;

    // ALU operation codes
    localparam alu_op_t ALU_ADD   = 5'h00;
    localparam alu_op_t ALU_ADDU  = 5'h01;
    localparam alu_op_t ALU_SUB   = 5'h02;
    localparam alu_op_t ALU_SUBU  = 5'h03;
    localparam alu_op_t ALU_AND   = 5'h04;
    localparam alu_op_t ALU_OR    = 5'h05;
    localparam alu_op_t ALU_XOR   = 5'h06;
    localparam alu_op_t ALU_NOR   = 5'h07;
    localparam alu_op_t ALU_SLT   = 5'h08;
    localparam alu_op_t ALU_SLTU  = 5'h09;
    localparam alu_op_t ALU_SLL   = 5'h0A;
    localparam alu_op_t ALU_SRL   = 5'h0B;
    localparam alu_op_t ALU_SRA   = 5'h0C;
    localparam alu_op_t ALU_SLLV  = 5'h0D;
    localparam alu_op_t ALU_SRLV  = 5'h0E;
    localparam alu_op_t ALU_SRAV  = 5'h0F;
    // LUI only ever arrives from the main decoder as a pass-through class;
    // the funct decoder never emits it.
    localparam alu_op_t ALU_LUI   = 5'h10;
    localparam alu_op_t ALU_MULT  = 5'h11;
    localparam alu_op_t ALU_MULTU = 5'h12;
    localparam alu_op_t ALU_DIV   = 5'h13;
    localparam alu_op_t ALU_DIVU  = 5'h14;
    localparam alu_op_t ALU_MFHI  = 5'h15;
    localparam alu_op_t ALU_MFLO  = 5'h16;
    localparam alu_op_t ALU_MTHI  = 5'h17;
    localparam alu_op_t ALU_MTLO  = 5'h18;
    localparam alu_op_t ALU_JR    = 5'h19;
    localparam alu_op_t ALU_JALR  = 5'h1A;
    localparam alu_op_t ALU_NOP   = 5'h1E;
    localparam alu_op_t ALU_RTYPE = 5'h1F;

    // MIPS funct field values
    localparam funct_t FN_SLL   = 6'h00;
    localparam funct_t FN_SRL   = 6'h02;
    localparam funct_t FN_SRA   = 6'h03;
    localparam funct_t FN_SLLV  = 6'h04;
    localparam funct_t FN_SRLV  = 6'h06;
    localparam funct_t FN_SRAV  = 6'h07;
    localparam funct_t FN_JR    = 6'h08;
    localparam funct_t FN_JALR  = 6'h09;
    localparam funct_t FN_MFHI  = 6'h10;
    localparam funct_t FN_MTHI  = 6'h11;
    localparam funct_t FN_MFLO  = 6'h12;
    localparam funct_t FN_MTLO  = 6'h13;
    localparam funct_t FN_MULT  = 6'h18;
    localparam funct_t FN_MULTU = 6'h19;
    localparam funct_t FN_DIV   = 6'h1A;
    localparam funct_t FN_DIVU  = 6'h1B;
    localparam funct_t FN_ADD   = 6'h20;
    localparam funct_t FN_ADDU  = 6'h21;
    localparam funct_t FN_SUB   = 6'h22;
    localparam funct_t FN_SUBU  = 6'h23;
    localparam funct_t FN_AND   = 6'h24;
    localparam funct_t FN_OR    = 6'h25;
    localparam funct_t FN_XOR   = 6'h26;
    localparam funct_t FN_NOR   = 6'h27;
    localparam funct_t FN_SLT   = 6'h2A;
    localparam funct_t FN_SLTU  = 6'h2B;

    // True for every funct value that has an ALU operation code.
    function automatic logic is_listed_funct(input funct_t f);
        logic listed;
        listed = 1'b0;
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_JR, FN_JALR,
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: listed = 1'b1;
            default:         listed = 1'b0;
        endcase
        return listed;
    endfunction

endpackage

// File: rtl/alu_funct_dec.sv
// -----------------------------------------------------------------------------
// alu_funct_dec -- MIPS R-type funct field to ALU operation code table.
//
// Parameters:
//   NOP_CODE : code returned for funct values with no ALU operation
// Ports:
//   funccode : input  [5:0] R-type funct field
//   code     : output [4:0] ALU operation code for that funct
//   illegal  : output       1 when funccode has no entry in the table
//
// Purely combinational; every funct value resolves through the default arm,
// so no X can leave this block for a 2-state input.
// -----------------------------------------------------------------------------
module alu_funct_dec
    import alu_pkg::*;
#(
    parameter logic [4:0] NOP_CODE = ALU_NOP
) (
    input  logic [5:0] funccode,
    output logic [4:0] code,
    output logic       illegal
);

    always_comb begin
        code    = NOP_CODE;
        illegal = 1'b0;
        case (funccode)
            FN_ADD:   code = ALU_ADD;
            FN_ADDU:  code = ALU_ADDU;
            FN_SUB:   code = ALU_SUB;
            FN_SUBU:  code = ALU_SUBU;
            FN_AND:   code = ALU_AND;
            FN_OR:    code = ALU_OR;
            FN_XOR:   code = ALU_XOR;
            FN_NOR:   code = ALU_NOR;
            FN_SLT:   code = ALU_SLT;
            FN_SLTU:  code = ALU_SLTU;
            FN_SLL:   code = ALU_SLL;
            FN_SRL:   code = ALU_SRL;
            FN_SRA:   code = ALU_SRA;
            FN_SLLV:  code = ALU_SLLV;
            FN_SRLV:  code = ALU_SRLV;
            FN_SRAV:  code = ALU_SRAV;
            FN_MULT:  code = ALU_MULT;
            FN_MULTU: code = ALU_MULTU;
            FN_DIV:   code = ALU_DIV;
            FN_DIVU:  code = ALU_DIVU;
            FN_MFHI:  code = ALU_MFHI;
            FN_MFLO:  code = ALU_MFLO;
            FN_MTHI:  code = ALU_MTHI;
            FN_MTLO:  code = ALU_MTLO;
            FN_JR:    code = ALU_JR;
            FN_JALR:  code = ALU_JALR;
            default: begin
                code    = NOP_CODE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_cu.sv
// -----------------------------------------------------------------------------
// alu_cu -- ALU control unit.
//
// Turns the main decoder's ALU operation class into the final ALU operation
// code. When ALUOP equals RTYPE_OP the funct field is decoded; any other
// ALUOP value is forwarded unchanged (this is how LUI, immediate ops and
// branches reach the ALU).
//
// Parameters:
//   RTYPE_OP : ALUOP value that selects funct decode
//   NOP_CODE : code emitted for an unrecognised funct under RTYPE_OP
// Ports:
//   clk          : input        clock, rising edge (used only by illegal_flag)
//   rst_n        : input        asynchronous active-low reset
//   ALUOP        : input  [4:0] ALU operation class
//   funccode     : input  [5:0] R-type funct field
//   ALUOPCtrl    : output [4:0] final ALU operation code (combinational)
//   illegal_flag : output       sticky "unlisted funct seen" flag, only when
//                               ALU_CU_ILLEGAL_FLAG_EN is defined
//
// Build option ALU_CU_ILLEGAL_FLAG_EN: adds illegal_flag and its single flop.
// Without it the block is flop-free and clk/rst_n are tied off internally.
// -----------------------------------------------------------------------------
module alu_cu
    import alu_pkg::*;
#(
    parameter logic [4:0] RTYPE_OP = ALU_RTYPE,
    parameter logic [4:0] NOP_CODE = ALU_NOP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] ALUOP,
    input  logic [5:0] funccode,
    output logic [4:0] ALUOPCtrl
`ifdef ALU_CU_ILLEGAL_FLAG_EN
    ,
    output logic       illegal_flag
`endif
);

    logic [4:0] dec_code;
    logic       dec_illegal;
    logic       is_rtype;

    alu_funct_dec #(
        .NOP_CODE (NOP_CODE)
    ) u_funct_dec (
        .funccode (funccode),
        .code     (dec_code),
        .illegal  (dec_illegal)
    );

    assign is_rtype = (ALUOP == RTYPE_OP);

    // Zero-latency select: the output tracks the inputs within the same
    // cycle and is never touched by reset.
    always_comb begin
        ALUOPCtrl = ALUOP;
        if (is_rtype) begin
            ALUOPCtrl = dec_code;
        end
    end

`ifdef ALU_CU_ILLEGAL_FLAG_EN
    // Sticky: once an unlisted funct is sampled under RTYPE_OP the flag stays
    // high until the next reset, so software can poll it long after the event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_flag <= 1'b0;
        end else if (is_rtype && dec_illegal) begin
            illegal_flag <= 1'b1;
        end
    end
`else
    // Keep the port list stable across builds; these inputs have no load here.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, dec_illegal};
`endif

endmodule

// File: tb/tb_alu_cu.sv
// -----------------------------------------------------------------------------
// tb_alu_cu -- self-checking bench for alu_cu.
//
// The driver applies one input vector just after each rising edge and pushes
// the reference model's answer into exp_q; the monitor pops and compares on
// the following falling edge. The reference model is a lookup over a list of
// (funct, code) pairs written straight from the operation table.
// Covers the optional ALU_CU_ILLEGAL_FLAG_EN build when that macro is defined.
// -----------------------------------------------------------------------------
module tb_alu_cu;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [4:0] ALUOP;
    logic [5:0] funccode;
    logic [4:0] ALUOPCtrl;
`ifdef ALU_CU_ILLEGAL_FLAG_EN
    logic       illegal_flag;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_cu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALUOP        (ALUOP),
        .funccode     (funccode),
        .ALUOPCtrl    (ALUOPCtrl)
`ifdef ALU_CU_ILLEGAL_FLAG_EN
        ,
        .illegal_flag (illegal_flag)
`endif
    );

    // ---------------- reference model ----------------
    localparam int NTBL = 26;
    logic [5:0] tbl_f [NTBL] = '{
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
        6'h18, 6'h19, 6'h1A, 6'h1B,
        6'h10, 6'h12, 6'h11, 6'h13,
        6'h08, 6'h09};
    logic [4:0] tbl_c [NTBL] = '{
        5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
        5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
        5'h11, 5'h12, 5'h13, 5'h14,
        5'h15, 5'h16, 5'h17, 5'h18,
        5'h19, 5'h1A};

    function automatic logic [4:0] model(input logic [4:0] op, input logic [5:0] f);
        if (op != 5'h1F) return op;
        for (int i = 0; i < NTBL; i++) begin
            if (tbl_f[i] == f) return tbl_c[i];
        end
        return 5'h1E;
    endfunction

    // ---------------- scoreboard ----------------
    logic [4:0]  exp_q[$];
    logic [10:0] in_q[$];
    int checks   = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [4:0]  e;
            logic [10:0] iv;
            e  = exp_q.pop_front();
            iv = in_q.pop_front();
            checks++;
            if (ALUOPCtrl !== e) begin
                failures++;
                $display("FAIL aluopctrl ALUOP=%h funccode=%h got=%h expected=%h",
                         iv[10:6], iv[5:0], ALUOPCtrl, e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [4:0] op, input logic [5:0] f);
        @(posedge clk);
        ALUOP    = op;
        funccode = f;
        exp_q.push_back(model(op, f));
        in_q.push_back({op, f});
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, got, want);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        ALUOP    = 5'h00;
        funccode = 6'h00;

        // Output is combinational and must ignore reset.
        drive(5'h1F, 6'h20);
        drive(5'h02, 6'h24);
        drive(5'h1F, 6'h3F);
        drive(5'h10, 6'h00);
`ifdef ALU_CU_ILLEGAL_FLAG_EN
        @(posedge clk);
        #1 check_bit("flag_in_reset", illegal_flag, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

`ifdef ALU_CU_ILLEGAL_FLAG_EN
        drive(5'h1F, 6'h20);
        repeat (3) @(posedge clk);
        #1 check_bit("flag_legal_idle", illegal_flag, 1'b0);
        drive(5'h1F, 6'h3F);
        @(posedge clk);
        #1 check_bit("flag_set", illegal_flag, 1'b1);
        drive(5'h1F, 6'h20);
        drive(5'h00, 6'h00);
        repeat (2) @(posedge clk);
        #1 check_bit("flag_sticky", illegal_flag, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_bit("flag_async_clear", illegal_flag, 1'b0);
        #1 rst_n = 1'b1;
`endif

        // Directed: ADD and the pass-through cases.
        drive(5'h1F, 6'h20);
        drive(5'h02, 6'h24);
        drive(5'h10, 6'h00);

        // Full funct sweep under the R-type selector.
        for (int f = 0; f < 64; f++) begin
            drive(5'h1F, 6'(f));
        end

        // Random vectors, one per edge; half of them R-type.
        for (int n = 0; n < 120; n++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 1) == 1) ? 5'h1F : 5'($urandom_range(0, 31));
            drive(op, 6'($urandom_range(0, 63)));
        end

        // Drain with a bound.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
